tff_mode_counter: RTL



---
 rtl/tff_mode_counter_pkg.sv | 11 +
 rtl/tff_mode_counter_if.sv | 28 ++
 rtl/tff_mode_counter_t_ff_cell.sv | 21 ++
 rtl/tff_mode_counter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tff_mode_counter_pkg.sv
// Shared mode encoding for the T-flip-flop mode counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tff_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

endpackage

// File: rtl/tff_mode_counter_if.sv
// Control/data bundle between a counter user (master) and the counter (slave).
// Latency: none, plain wires.
// Backpressure: none; the master qualifies activity with en and load.
interface tff_mode_counter_if #(
    parameter int WIDTH = 8
);
    import tff_pkg::*;

    logic             en;
    logic             load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] tmask;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, load, mode, d, tmask,
        input  q, tc, wrap
    );

    modport slave (
        input  en, load, mode, d, tmask,
        output q, tc, wrap
    );

endinterface

// File: rtl/tff_mode_counter_t_ff_cell.sv
// Single-bit T flip-flop with a per-instance reset value.
// Latency: 1 cycle from t to q.
// Backpressure: none; t=0 holds the bit.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic rst_val,
    output logic q
);

    // Invert on t, otherwise hold; async active-low reset loads rst_val.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= rst_val;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_mode_counter.sv
// WIDTH-bit load/up/down/masked-toggle counter built from per-bit T cells, modulo MODULUS.
// Latency: q and wrap update 1 cycle after the edge; tc is combinational.
// Backpressure: none; load overrides, en=0 or mode hold freezes q.
// Optional build macro TFF_MODE_COUNTER_SATURATE_EN: saturate at the ends instead of wrapping.
module tff_mode_counter
    import tff_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic                clk,
    input  logic                rst,
    tff_mode_counter_if.slave   bus
);

    // MODULUS extended by one bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_cur;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] r_tgl;
    logic             wrap_next;
    logic             wrap_q;

    // Next-state selection: load first, then en, then mode.
    always_comb begin
        q_next    = q_cur;
        wrap_next = 1'b0;
        r_tgl     = q_cur ^ bus.tmask;
        if (bus.load) begin
            // Out-of-range load values clip to the top of the range.
            if ({1'b0, bus.d} < MOD_EXT) begin
                q_next = bus.d;
            end else begin
                q_next = MAX_Q;
            end
        end else if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: begin
                    q_next = q_cur;
                end
                MODE_UP: begin
                    if (q_cur == MAX_Q) begin
`ifdef TFF_MODE_COUNTER_SATURATE_EN
                        q_next    = q_cur;
`else
                        q_next    = '0;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        q_next = q_cur + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q_cur == '0) begin
`ifdef TFF_MODE_COUNTER_SATURATE_EN
                        q_next    = q_cur;
`else
                        q_next    = MAX_Q;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        q_next = q_cur - ONE;
                    end
                end
                MODE_TOGGLE: begin
                    if ({1'b0, r_tgl} < MOD_EXT) begin
                        q_next = r_tgl;
                    end else begin
`ifdef TFF_MODE_COUNTER_SATURATE_EN
                        q_next    = MAX_Q;
`else
                        q_next    = '0;
                        wrap_next = 1'b1;
`endif
                    end
                end
                default: begin
                    q_next = q_cur;
                end
            endcase
        end
    end

    // The cells only ever see a toggle request; bits that stay put get t=0.
    assign t_vec = q_cur ^ q_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            t_ff_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .t       (t_vec[gi]),
                .rst_val (RST_Q[gi]),
                .q       (q_cur[gi])
            );
        end
    endgenerate

    // One-cycle wrap pulse; cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_next;
        end
    end

    assign bus.q    = q_cur;
    assign bus.wrap = wrap_q;
    // Terminal count looks at the current state only; a pending load masks it.
    assign bus.tc   = bus.en & ~bus.load &
                      (((bus.mode == MODE_UP)   && (q_cur == MAX_Q)) ||
                       ((bus.mode == MODE_DOWN) && (q_cur == '0)));

endmodule
